// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and byte-lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_REQ  = 2'd1,
    LD_WAIT = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Byte-lane enables for an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    case (funct3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Unsupported encodings (011/110/111) are reported as misaligned too.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3)
      F3_LB, F3_LBU: mis = 1'b0;
      F3_LH, F3_LHU: mis = off[0];
      F3_LW:         mis = (off != 2'b00);
      default:       mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Right-aligns the addressed bytes of a DM read word and sign/zero-extends them.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted_s;

  // Move the addressed byte/half to bit 0, then extend according to size/sign.
  always_comb begin
    shifted_s = word_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_LB:   result_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LH:   result_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LW:   result_o = shifted_s;
      F3_LBU:  result_o = {24'h00_0000, shifted_s[7:0]};
      F3_LHU:  result_o = {16'h0000, shifted_s[15:0]};
      default: result_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: single-cycle stores, stalling loads with timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       st_data_i,
  output logic              cs_o,
  output logic              wr_o,
  output logic [3:0]        mask_o,
  output logic [31:0]       data_wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              lwstall_o,
  input  logic              valid_dm_i,
  input  logic [31:0]       data_rd_i,
  output logic [31:0]       ld_data_o,
  output logic              ld_valid_o,
  output logic              err_misalign_o,
  output logic              err_timeout_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              ld_valid_q, ld_valid_d;
  logic              err_mis_q, err_mis_d;
  logic              err_to_q, err_to_d;

  logic              misalign_s;
  logic              store_cycle_s;
  logic [31:0]       aligned_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^addr_i[31:ADDR_W+2];
  assign misalign_s    = is_misaligned(funct3_i, addr_i[1:0]);
  assign store_cycle_s = (state_q == IDLE) && req_valid_i && is_store_i && !misalign_s;

  load_align u_load_align (
    .word_i   (data_rd_i),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .result_o (aligned_s)
  );

  // Next-state logic: request acceptance, DM response wait and timeout counting.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    f3_d       = f3_q;
    waddr_d    = waddr_q;
    cnt_d      = cnt_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && misalign_s) begin
          err_mis_d = 1'b1;
        end else if (req_valid_i && !is_store_i) begin
          off_d   = addr_i[1:0];
          f3_d    = funct3_i;
          waddr_d = addr_i[ADDR_W+1:2];
          state_d = LD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      LD_REQ: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = LD_WAIT;
      end
      LD_WAIT: begin
        if (valid_dm_i) begin
          ld_data_d  = aligned_s;
          ld_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ld_data_d = 32'h0000_0000;
          err_to_d  = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output flops; reset abandons any load in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      waddr_q    <= {ADDR_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ld_data_q  <= 32'h0000_0000;
      ld_valid_q <= 1'b0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      waddr_q    <= waddr_d;
      cnt_q      <= cnt_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
    end
  end

  // DM control: stores go out combinationally in IDLE, loads hold a read from the latched address.
  always_comb begin
    cs_o      = 1'b1;
    wr_o      = 1'b1;
    mask_o    = 4'b0000;
    data_wr_o = 32'h0000_0000;
    addr_o    = addr_i[ADDR_W+1:2];
    case (state_q)
      IDLE: begin
        if (store_cycle_s) begin
          cs_o      = 1'b0;
          wr_o      = 1'b0;
          mask_o    = lane_mask(funct3_i, addr_i[1:0]);
          data_wr_o = st_data_i << {addr_i[1:0], 3'b000};
        end else begin
          cs_o = 1'b1;
        end
      end
      LD_REQ, LD_WAIT: begin
        cs_o   = 1'b0;
        mask_o = lane_mask(f3_q, off_q);
        addr_o = waddr_q;
      end
      default: cs_o = 1'b1;
    endcase
  end

  assign req_ready_o    = (state_q == IDLE);
  assign lwstall_o      = (state_q == LD_REQ);
  assign ld_data_o      = ld_data_q;
  assign ld_valid_o     = ld_valid_q;
  assign err_misalign_o = err_mis_q;
  assign err_timeout_o  = err_to_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit with an arithmetic reference model.
module tb_load_store_unit;

  localparam int ADDR_W  = 20;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid_i, is_store_i;
  logic [2:0]        funct3_i;
  logic [31:0]       addr_i, st_data_i, data_rd_i;
  logic              req_ready_o, cs_o, wr_o, lwstall_o;
  logic [3:0]        mask_o;
  logic [31:0]       data_wr_o, ld_data_o;
  logic [ADDR_W-1:0] addr_o;
  logic              valid_dm_i;
  logic              ld_valid_o, err_misalign_o, err_timeout_o;
  logic              dm_enable;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i), .st_data_i(st_data_i),
    .cs_o(cs_o), .wr_o(wr_o), .mask_o(mask_o), .data_wr_o(data_wr_o), .addr_o(addr_o),
    .lwstall_o(lwstall_o), .valid_dm_i(valid_dm_i), .data_rd_i(data_rd_i),
    .ld_data_o(ld_data_o), .ld_valid_o(ld_valid_o),
    .err_misalign_o(err_misalign_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  // Data memory model: valid is lwstall registered one cycle, suppressible to force timeouts.
  always @(posedge clk or negedge rst) begin
    if (!rst) valid_dm_i <= 1'b0;
    else      valid_dm_i <= lwstall_o & dm_enable;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from acceptance to completion, every expectation from the access rules.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] dat, input logic respond);
    int          size, off, m;
    logic        mis;
    logic [31:0] edata, eld, eaddr;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(addr % 32'd4);
    mis   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((addr % size) != 0);
    m     = ((1 << size) - 1) << off;
    edata = dat << (8 * off);
    eaddr = (addr >> 2) & 32'h000F_FFFF;
    eld   = dat >> (8 * off);
    if (size == 1) begin
      eld = eld & 32'h0000_00FF;
      if (!f3[2] && eld >= 32'h80) eld = eld | 32'hFFFF_FF00;
    end else if (size == 2) begin
      eld = eld & 32'h0000_FFFF;
      if (!f3[2] && eld >= 32'h8000) eld = eld | 32'hFFFF_0000;
    end

    @(negedge clk);
    req_valid_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = addr;
    st_data_i = dat; data_rd_i = dat; dm_enable = respond;
    #1;
    chk("ready_at_accept", req_ready_o, 32'd1);
    if (mis) begin
      chk("cs_misalign", cs_o, 32'd1);
    end else if (st) begin
      chk("st_cs", cs_o, 32'd0);
      chk("st_wr", wr_o, 32'd0);
      chk("st_mask", mask_o, 32'(m));
      chk("st_data", data_wr_o, edata);
      chk("st_addr", addr_o, eaddr);
    end else begin
      chk("ld_cs_idle", cs_o, 32'd1);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    if (mis || st) begin
      chk("err_misalign", err_misalign_o, 32'(mis));
      chk("ready_after", req_ready_o, 32'd1);
      chk("cs_after", cs_o, 32'd1);
      chk("no_ld_valid", ld_valid_o, 32'd0);
    end else begin
      chk("ld_addr", addr_o, eaddr);
      chk("ld_wr", wr_o, 32'd1);
      for (int k = 1; k <= TIMEOUT + 3; k++) begin
        if (k > 1) begin
          @(negedge clk);
          #1;
        end
        chk("lwstall", lwstall_o, 32'(k == 1));
        chk("ld_valid", ld_valid_o, 32'(respond && k == 3));
        chk("err_timeout", err_timeout_o, 32'(!respond && k == TIMEOUT + 2));
        chk("ready_wait", req_ready_o, 32'(respond ? (k >= 3) : (k >= TIMEOUT + 2)));
        if (respond ? (k < 3) : (k < TIMEOUT + 2)) chk("cs_wait", cs_o, 32'd0);
      end
      chk("ld_data", ld_data_o, respond ? eld : 32'h0000_0000);
    end
  endtask

  logic [2:0] f3_tbl [8];

  initial begin
    f3_tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    rst = 1'b0; req_valid_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'd0;
    addr_i = 32'h0; st_data_i = 32'h0; data_rd_i = 32'h0; dm_enable = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cs", cs_o, 32'd1);
    chk("rst_wr", wr_o, 32'd1);
    chk("rst_mask", mask_o, 32'd0);
    chk("rst_lwstall", lwstall_o, 32'd0);
    chk("rst_ld_valid", ld_valid_o, 32'd0);
    chk("rst_ld_data", ld_data_o, 32'd0);
    chk("rst_errs", {err_misalign_o, err_timeout_o}, 32'd0);
    chk("rst_ready", req_ready_o, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    do_req(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1'b1);   // sb
    do_req(1'b0, 3'b001, 32'h0000_0102, 32'h8001_1234, 1'b1);   // lh
    do_req(1'b0, 3'b100, 32'h0000_0101, 32'h0000_F300, 1'b1);   // lbu
    do_req(1'b0, 3'b000, 32'h0000_0101, 32'h0000_F300, 1'b1);   // lb
    do_req(1'b1, 3'b010, 32'h0000_0102, 32'hDEAD_BEEF, 1'b1);   // sw misaligned
    do_req(1'b0, 3'b010, 32'h0000_0200, 32'h1234_5678, 1'b0);   // lw timeout
    do_req(1'b0, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 1'b1);   // lw

    // Reset while waiting for the DM.
    @(negedge clk);
    req_valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0300;
    dm_enable = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_cs", cs_o, 32'd1);
    chk("midrst_lwstall", lwstall_o, 32'd0);
    chk("midrst_ready", req_ready_o, 32'd1);
    chk("midrst_ld_data", ld_data_o, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_pulse", {ld_valid_o, err_timeout_o}, 32'd0);
    rst = 1'b1;
    do_req(1'b0, 3'b101, 32'h0000_0302, 32'h9ABC_0011, 1'b1);   // lhu after reset

    for (int i = 0; i < 30; i++) begin
      logic st;
      st = 1'($urandom_range(0, 1));
      do_req(st, st ? 3'($urandom_range(0, 2)) : f3_tbl[$urandom_range(0, 7)],
             $urandom, $urandom, 1'($urandom_range(0, 7) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
